// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    localparam int              REG_AW      = 5;
    localparam logic [REG_AW-1:0] REG_ZERO  = 5'd0;
    localparam int              MUL_LAT_MIN = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX hazard inputs and pipeline register controls
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              ex_mem_read;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_branch_taken;
    logic              ex_mul_start;
    logic              stat_clr;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              idex_hold;
    logic              exmem_bubble;
    logic              busy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_reg_write,
               ex_dst, ex_branch_taken, ex_mul_start, stat_clr,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, idex_hold, exmem_bubble,
               busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_reg_write,
               ex_dst, ex_branch_taken, ex_mul_start, stat_clr,
        output pc_we, ifid_we, ifid_flush, idex_bubble, idex_hold, exmem_bubble,
               busy, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_luse_detect.sv
// rtl/pipe_hazard_ctrl_luse_detect.sv - load-use comparator, shared with the forwarding unit
module luse_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_dst,
    output logic              luse
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs && (id_rs == ex_dst);
    assign rt_hit = id_use_rt && (id_rt == ex_dst);

    // $zero is never a real dependency even if a load targets it
    assign luse = ex_mem_read && ex_reg_write && (ex_dst != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with mult/div hold and statistics
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    generate
        if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > 15) begin : g_bad_mul_lat
            $error("pipe_hazard_ctrl: MUL_LAT must be within 3..15");
        end
    endgenerate

    localparam logic [0:0] S_RUN     = RUN;
    localparam logic [0:0] S_MUL     = MUL;
    localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - MUL_LAT_MIN);

    logic [0:0]       state, state_nxt;
    logic [3:0]       mcnt, mcnt_nxt;
    logic             luse;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    luse_detect u_luse (
        .id_rs        (hz.id_rs),
        .id_rt        (hz.id_rt),
        .id_use_rs    (hz.id_use_rs),
        .id_use_rt    (hz.id_use_rt),
        .ex_mem_read  (hz.ex_mem_read),
        .ex_reg_write (hz.ex_reg_write),
        .ex_dst       (hz.ex_dst),
        .luse         (luse)
    );

    always_comb begin
        hz.pc_we        = 1'b1;
        hz.ifid_we      = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_bubble  = 1'b0;
        hz.idex_hold    = 1'b0;
        hz.exmem_bubble = 1'b0;
        hz.busy         = 1'b0;
        state_nxt       = state;
        mcnt_nxt        = mcnt;
        if (!rst_n) begin
            // pipeline fills with NOPs while reset is held
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (state == S_MUL) begin
            hz.pc_we        = 1'b0;
            hz.ifid_we      = 1'b0;
            hz.idex_hold    = 1'b1;
            hz.exmem_bubble = 1'b1;
            hz.busy         = 1'b1;
            if (mcnt == 4'd0) begin
                state_nxt = S_RUN;
            end else begin
                mcnt_nxt = mcnt - 4'd1;
            end
        end else if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (hz.ex_mul_start) begin
            hz.pc_we        = 1'b0;
            hz.ifid_we      = 1'b0;
            hz.idex_hold    = 1'b1;
            hz.exmem_bubble = 1'b1;
            state_nxt       = S_MUL;
            mcnt_nxt        = MCNT_INIT;
        end else if (luse) begin
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            mcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
        end
    end

    // clear wins over a same-cycle increment; both counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hz.stat_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!hz.pc_we && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (hz.ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks of pipe_hazard_ctrl against a cycle model
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // behavioural model: remaining MUL-state cycles and plain integer counters
    int   m_mul_left;
    int   m_stall;
    int   m_flush;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
        hz.ex_mem_read = 1'b0; hz.ex_reg_write = 1'b0; hz.ex_dst = 5'd0;
        hz.ex_branch_taken = 1'b0; hz.ex_mul_start = 1'b0; hz.stat_clr = 1'b0;
    endtask

    task automatic set_luse(input logic [4:0] dst);
        hz.ex_mem_read = 1'b1; hz.ex_reg_write = 1'b1; hz.ex_dst = dst;
        hz.id_rs = dst; hz.id_use_rs = 1'b1;
    endtask

    // one cycle: check combinational controls and counters, then advance the model
    task automatic step();
        logic [6:0] exp_o, obs_o;
        bit lu;
        if (!rst_n) begin
            m_mul_left = 0; m_stall = 0; m_flush = 0;
        end
        @(negedge clk);
        lu = hz.ex_mem_read && hz.ex_reg_write && hz.ex_dst != 0 &&
             ((hz.id_use_rs && hz.id_rs == hz.ex_dst) || (hz.id_use_rt && hz.id_rt == hz.ex_dst));
        // {pc_we, ifid_we, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy}
        if (!rst_n)                 exp_o = 7'b0011000;
        else if (m_mul_left > 0)    exp_o = 7'b0000111;
        else if (hz.ex_branch_taken) exp_o = 7'b1111000;
        else if (hz.ex_mul_start)   exp_o = 7'b0000110;
        else if (lu)                exp_o = 7'b0001000;
        else                        exp_o = 7'b1100000;
        obs_o = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_bubble,
                 hz.idex_hold, hz.exmem_bubble, hz.busy};
        chk("ctrl", 32'(obs_o), 32'(exp_o));
        chk("hold_bubble_excl", 32'(hz.idex_hold & hz.idex_bubble), 32'd0);
        chk("stall_cnt", 32'(hz.stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(hz.flush_cnt), 32'(m_flush));
        if (rst_n) begin
            if (m_mul_left > 0) m_mul_left--;
            else if (!hz.ex_branch_taken && hz.ex_mul_start) m_mul_left = MUL_LAT - 2;
            if (hz.stat_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!exp_o[6] && m_stall < CNT_MAX) m_stall++;
                if (exp_o[4] && m_flush < CNT_MAX) m_flush++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        idle(); hz.stat_clr = 1'b1; step(); hz.stat_clr = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_mul_left = 0; m_stall = 0; m_flush = 0;
        rst_n = 1'b0;
        idle();

        // reset held three cycles, then release
        repeat (3) step();
        chk("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // load-use: exactly one stall, then $zero destination causes none
        clear_stats();
        set_luse(5'd8); step();
        idle(); step();
        chk("luse_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        set_luse(5'd0); step();
        idle(); step();
        chk("luse_zero_stall_cnt", 32'(hz.stall_cnt), 32'd1);

        // mult/div with hazards injected in the first MUL cycle
        clear_stats();
        hz.ex_mul_start = 1'b1; step();
        idle(); set_luse(5'd9); hz.ex_branch_taken = 1'b1; step();
        idle(); step();
        step();
        chk("mul_stall_cnt", 32'(hz.stall_cnt), 32'd3);
        chk("mul_flush_cnt", 32'(hz.flush_cnt), 32'd0);

        // branch wins over mult/div in RUN
        clear_stats();
        hz.ex_branch_taken = 1'b1; hz.ex_mul_start = 1'b1; step();
        idle(); step();
        chk("br_mul_flush_cnt", 32'(hz.flush_cnt), 32'd1);
        chk("br_mul_stall_cnt", 32'(hz.stall_cnt), 32'd0);

        // reset mid-MUL aborts the sequence
        hz.ex_mul_start = 1'b1; step();
        idle(); rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        chk("post_abort_busy", 32'(hz.busy), 32'd0);
        chk("post_abort_pc_we", 32'(hz.pc_we), 32'd1);

        // saturation, then clear with a stall pending in the same cycle
        clear_stats();
        set_luse(5'd3);
        repeat ((1 << CNT_W) + 5) step();
        chk("sat_stall_cnt", 32'(hz.stall_cnt), 32'hFFFF);
        hz.stat_clr = 1'b1; step();
        idle(); step();
        chk("clr_stall_cnt", 32'(hz.stall_cnt), 32'd0);

        // randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            hz.id_rs           = 5'($urandom_range(0, 3));
            hz.id_rt           = 5'($urandom_range(0, 3));
            hz.ex_dst          = 5'($urandom_range(0, 3));
            hz.id_use_rs       = 1'($urandom_range(0, 1));
            hz.id_use_rt       = 1'($urandom_range(0, 1));
            hz.ex_mem_read     = 1'($urandom_range(0, 1));
            hz.ex_reg_write    = ($urandom_range(0, 3) != 0);
            hz.ex_branch_taken = ($urandom_range(0, 9) == 0);
            hz.ex_mul_start    = ($urandom_range(0, 9) == 0);
            hz.stat_clr        = ($urandom_range(0, 49) == 0);
            rst_n              = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
